// File: rtl/dig_clock_pkg.sv
// Shared types and constants for the digital-clock alarm/time-set controllers.
// ALARM_SNOOZE_EN adds the SNOOZE state to the FSM enum.
package dig_clock_pkg;

  localparam int HOUR_W = 6;
  localparam int MIN_W  = 7;

  localparam logic [3:0] SEL_NONE   = 4'b0000;
  localparam logic [3:0] SEL_MIN_L  = 4'b0001;
  localparam logic [3:0] SEL_MIN_H  = 4'b0010;
  localparam logic [3:0] SEL_HOUR_L = 4'b0100;
  localparam logic [3:0] SEL_HOUR_H = 4'b1000;

  localparam logic [3:0] UNIT_MAX        = 4'd9;
  localparam logic [2:0] MIN_TENS_MAX    = 3'd5;
  localparam logic [3:0] HOUR_UNIT_MAX_2 = 4'd3;
  localparam logic [1:0] HOUR_TENS_MAX   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
`ifdef ALARM_SNOOZE_EN
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
`else
    ST_RING   = 2'd2
`endif
  } alarm_fsm_t;

endpackage

// File: rtl/alarm_digit_inc.sv
// Combinational BCD next-value for hour/minute: increments the selected digit
// with per-digit wrap, no carries, and the 2x-hour units clamp.
module alarm_digit_inc
  import dig_clock_pkg::*;
(
  input  logic [HOUR_W-1:0] hour,
  input  logic [MIN_W-1:0]  minute,
  input  logic [3:0]        select_one,
  input  logic              inc,
  output logic [HOUR_W-1:0] hour_nxt,
  output logic [MIN_W-1:0]  minute_nxt
);

  logic [3:0] min_l;
  logic [2:0] min_h;
  logic [3:0] hour_l;
  logic [1:0] hour_h;
  logic [3:0] hour_l_max;
  logic [1:0] hour_h_inc;

  assign min_l  = minute[3:0];
  assign min_h  = minute[6:4];
  assign hour_l = hour[3:0];
  assign hour_h = hour[5:4];

  always_comb begin
    hour_nxt   = hour;
    minute_nxt = minute;
    hour_l_max = (hour_h == HOUR_TENS_MAX) ? HOUR_UNIT_MAX_2 : UNIT_MAX;
    hour_h_inc = (hour_h >= HOUR_TENS_MAX) ? 2'd0 : hour_h + 2'd1;
    if (inc) begin
      case (select_one)
        SEL_MIN_L:  minute_nxt[3:0] = (min_l >= UNIT_MAX) ? 4'd0 : min_l + 4'd1;
        SEL_MIN_H:  minute_nxt[6:4] = (min_h >= MIN_TENS_MAX) ? 3'd0 : min_h + 3'd1;
        SEL_HOUR_L: hour_nxt[3:0]   = (hour_l >= hour_l_max) ? 4'd0 : hour_l + 4'd1;
        SEL_HOUR_H: begin
          hour_nxt[5:4] = hour_h_inc;
          // entering the 20s must not leave an illegal 24..29
          if (hour_h_inc == HOUR_TENS_MAX && hour_l > HOUR_UNIT_MAX_2)
            hour_nxt[3:0] = HOUR_UNIT_MAX_2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm configuration editor, time comparator and ring sequencer.
// Optional ALARM_SNOOZE_EN adds a SNOOZE state entered by key_inc while ringing.
//
// state  | meaning
// IDLE   | alarm armed or off, watching for the match edge
// EDIT   | edit_mode high, keys edit the selected digit
// RING   | buzzer on, counting sec_tick to auto-stop
// SNOOZE | buzzer paused, counting sec_tick to re-ring (ALARM_SNOOZE_EN)
module alarm_set_ctrl
  import dig_clock_pkg::*;
#(
  parameter logic [HOUR_W-1:0] RST_HOUR    = 6'h07,
  parameter logic [MIN_W-1:0]  RST_MINUTE  = 7'h00,
  parameter int                RING_SECS   = 30,
  parameter int                SNOOZE_SECS = 300
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              edit_mode,
  input  logic              key_next,
  input  logic              key_inc,
  input  logic              key_onoff,
  input  logic              sec_tick,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_minute,
  output logic              state,
  output logic [3:0]        select_one,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic [MIN_W-1:0]  alarm_minute,
  output logic              ring
);

  // one counter serves both intervals, so size it for the longer one
  localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SECS - 1);
`endif

  alarm_fsm_t        fsm_q, fsm_nxt;
  logic              alarm_en_q, alarm_en_nxt;
  logic [3:0]        sel_q, sel_nxt;
  logic [HOUR_W-1:0] hour_q, hour_nxt, inc_hour;
  logic [MIN_W-1:0]  min_q, min_nxt, inc_min;
  logic              ring_q, ring_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              match_q, match_d, edit_mode_d;
  logic              any_key, trigger, edit_rise, ring_done, counting;

  alarm_digit_inc u_digit_inc (
    .hour       (hour_q),
    .minute     (min_q),
    .select_one (sel_q),
    .inc        (key_inc),
    .hour_nxt   (inc_hour),
    .minute_nxt (inc_min)
  );

  assign any_key   = key_next | key_inc | key_onoff;
  assign trigger   = alarm_en_q & match_q & ~match_d;
  assign edit_rise = edit_mode & ~edit_mode_d;
  assign ring_done = sec_tick && (cnt_q == RING_LAST);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) fsm_q <= ST_IDLE;
    else        fsm_q <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (edit_mode)    fsm_nxt = ST_EDIT;
        else if (trigger) fsm_nxt = ST_RING;
      end
      ST_EDIT: begin
        if (!edit_mode) fsm_nxt = ST_IDLE;
      end
      ST_RING: begin
`ifdef ALARM_SNOOZE_EN
        if (key_inc)        fsm_nxt = ST_SNOOZE;
        else
`endif
        if (any_key)        fsm_nxt = ST_IDLE;
        else if (edit_rise) fsm_nxt = ST_EDIT;
        else if (ring_done) fsm_nxt = ST_IDLE;
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (key_onoff)      fsm_nxt = ST_IDLE;
        else if (edit_mode) fsm_nxt = ST_EDIT;
        else if (sec_tick && (cnt_q == SNZ_LAST)) fsm_nxt = ST_RING;
      end
`endif
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    alarm_en_nxt = alarm_en_q;
    sel_nxt      = SEL_NONE;
    hour_nxt     = hour_q;
    min_nxt      = min_q;
    cnt_nxt      = '0;
    ring_nxt     = (fsm_nxt == ST_RING);
    counting     = (fsm_q == ST_RING);
`ifdef ALARM_SNOOZE_EN
    if (fsm_q == ST_SNOOZE) counting = 1'b1;
    if (fsm_q == ST_SNOOZE && key_onoff) alarm_en_nxt = 1'b0;
`endif
    if (fsm_nxt == ST_EDIT) begin
      if (fsm_q != ST_EDIT) sel_nxt = SEL_MIN_L;
      else if (key_next)    sel_nxt = {sel_q[2:0], sel_q[3]};
      else                  sel_nxt = sel_q;
    end
    if (fsm_q == ST_EDIT && fsm_nxt == ST_EDIT) begin
      hour_nxt = inc_hour;
      min_nxt  = inc_min;
    end
    if ((fsm_q == ST_IDLE || fsm_q == ST_EDIT) && key_onoff)
      alarm_en_nxt = ~alarm_en_q;
    if (fsm_nxt == fsm_q) begin
      if (counting && sec_tick) cnt_nxt = cnt_q + CNT_W'(1);
      else                      cnt_nxt = cnt_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      alarm_en_q  <= 1'b0;
      sel_q       <= SEL_NONE;
      hour_q      <= RST_HOUR;
      min_q       <= RST_MINUTE;
      ring_q      <= 1'b0;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      match_d     <= 1'b0;
      edit_mode_d <= 1'b0;
    end else begin
      alarm_en_q  <= alarm_en_nxt;
      sel_q       <= sel_nxt;
      hour_q      <= hour_nxt;
      min_q       <= min_nxt;
      ring_q      <= ring_nxt;
      cnt_q       <= cnt_nxt;
      match_q     <= (cur_hour == hour_q) && (cur_minute == min_q);
      match_d     <= match_q;
      edit_mode_d <= edit_mode;
    end
  end

  assign state        = alarm_en_q;
  assign select_one   = sel_q;
  assign alarm_hour   = hour_q;
  assign alarm_minute = min_q;
  assign ring         = ring_q;

endmodule
